// File: rtl/fib_pkg.sv
// Shared types and constants for the Zeckendorf-to-binary decoder.
// Also provides a reference Fibonacci function for checking.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int FIB_W_DEF = 32;
  localparam int BIN_W_DEF = 16;
  localparam int ACC_W_DEF = 24;

  // F(1)=F(2)=1
  function automatic longint unsigned fib(input int n);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    a = 0;
    b = 1;
    for (int i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (n <= 0) ? 0 : b;
  endfunction

endpackage

// File: rtl/fibonacci_binary.sv
// Decodes a Fibonacci-coded word to binary, one code bit per clock.
// Weights advance as an iterative (wa, wb) pair alongside the shift.
module fibonacci_binary
  import fib_pkg::*;
#(
  parameter int FIB_W = FIB_W_DEF,
  parameter int BIN_W = BIN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             begin_f_b,
  input  logic [FIB_W-1:0] input_fibonacci,
  output logic             convert_done,
  output logic [BIN_W-1:0] fibonacci_binary_out,
  output logic             overflow,
  output logic             non_canonical
);

  localparam int IDX_W = $clog2(FIB_W);

  state_t             state;
  logic [FIB_W-1:0]   sr;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   wa;
  logic [ACC_W-1:0]   wb;
  logic               prev_bit;
  logic [IDX_W-1:0]   idx;
  logic               err;

  logic [ACC_W-1:0]   acc_nxt;
  logic [FIB_W-1:0]   sr_nxt;
  logic               err_nxt;
  logic               last;
  logic               ovf_nxt;

  always_comb begin
    acc_nxt = acc + (sr[0] ? wa : '0);
    sr_nxt  = sr >> 1;
    err_nxt = err | (sr[0] & prev_bit);
    last    = (sr_nxt == '0) || (idx == IDX_W'(FIB_W - 1));
    ovf_nxt = |acc_nxt[ACC_W-1:BIN_W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                <= IDLE;
      sr                   <= '0;
      acc                  <= '0;
      wa                   <= '0;
      wb                   <= '0;
      prev_bit             <= 1'b0;
      idx                  <= '0;
      err                  <= 1'b0;
      convert_done         <= 1'b0;
      fibonacci_binary_out <= '0;
      overflow             <= 1'b0;
      non_canonical        <= 1'b0;
    end else begin
      convert_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (begin_f_b) begin
            sr       <= input_fibonacci;
            acc      <= '0;
            wa       <= ACC_W'(1);
            wb       <= ACC_W'(2);
            prev_bit <= 1'b0;
            idx      <= '0;
            err      <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc      <= acc_nxt;
          err      <= err_nxt;
          prev_bit <= sr[0];
          sr       <= sr_nxt;
          wa       <= wb;
          wb       <= wa + wb;
          idx      <= idx + 1'b1;
          // Result registers load on the exit edge so DONE shows them
          if (last) begin
            state                <= DONE;
            convert_done         <= 1'b1;
            overflow             <= ovf_nxt;
            non_canonical        <= err_nxt;
            fibonacci_binary_out <= ovf_nxt ? '1 : acc_nxt[BIN_W-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_binary.sv
// Directed-vector bench for the Fibonacci-to-binary decoder.
// Expected values are hand-computed Zeckendorf sums.
module tb_fibonacci_binary;

  logic        clk;
  logic        rst;
  logic        begin_f_b;
  logic [31:0] input_fibonacci;
  logic        convert_done;
  logic [15:0] fibonacci_binary_out;
  logic        overflow;
  logic        non_canonical;

  int n_cmp;
  int n_bad;
  int done_cnt;
  int base;

  fibonacci_binary dut (
    .clk                  (clk),
    .rst                  (rst),
    .begin_f_b            (begin_f_b),
    .input_fibonacci      (input_fibonacci),
    .convert_done         (convert_done),
    .fibonacci_binary_out (fibonacci_binary_out),
    .overflow             (overflow),
    .non_canonical        (non_canonical)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (convert_done) done_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic conv(input string tag,
                      input logic [31:0] v,
                      input int exp_out,
                      input int exp_ovf,
                      input int exp_nc,
                      input int exp_lat);
    int n;
    @(negedge clk);
    begin_f_b       = 1'b1;
    input_fibonacci = v;
    @(negedge clk);
    begin_f_b       = 1'b0;
    input_fibonacci = $urandom;
    n = 1;
    while (!convert_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " lat"}, n, exp_lat);
    chk({tag, " out"}, fibonacci_binary_out, exp_out);
    chk({tag, " ovf"}, overflow, exp_ovf);
    chk({tag, " nc"}, non_canonical, exp_nc);
    @(negedge clk);
    chk({tag, " pulse"}, convert_done, 0);
    chk({tag, " hold"}, fibonacci_binary_out, exp_out);
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    done_cnt        = 0;
    rst             = 1'b0;
    begin_f_b       = 1'b0;
    input_fibonacci = '0;
    repeat (2) @(negedge clk);
    chk("rst done", convert_done, 0);
    chk("rst out", fibonacci_binary_out, 0);
    chk("rst ovf", overflow, 0);
    chk("rst nc", non_canonical, 0);
    rst = 1'b1;

    conv("zero", 32'h0, 0, 0, 0, 2);
    conv("a4", 32'h000000A4, 50, 0, 0, 9);
    conv("five", 32'h5, 4, 0, 0, 4);
    conv("three", 32'h3, 3, 0, 1, 3);
    conv("one", 32'h1, 1, 0, 0, 2);
    conv("bit22", 32'h0040_0000, 46368, 0, 0, 24);
    conv("bit23", 32'h0080_0000, 16'hFFFF, 1, 0, 25);
    conv("ones", 32'hFFFF_FFFF, 16'hFFFF, 1, 1, 33);

    // begin pulses during ACCUM are ignored
    base = done_cnt;
    @(negedge clk);
    begin_f_b       = 1'b1;
    input_fibonacci = 32'h000000A4;
    @(negedge clk);
    begin_f_b = 1'b0;
    @(negedge clk);
    begin_f_b = 1'b1;
    @(negedge clk);
    begin_f_b = 1'b0;
    @(negedge clk);
    begin_f_b = 1'b1;
    @(negedge clk);
    begin_f_b = 1'b0;
    repeat (15) @(negedge clk);
    chk("ign count", done_cnt - base, 1);
    chk("ign out", fibonacci_binary_out, 50);

    // held begin gives one conversion every k+2 cycles
    base = done_cnt;
    begin_f_b       = 1'b1;
    input_fibonacci = 32'h0;
    repeat (12) @(negedge clk);
    begin_f_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b count", done_cnt - base, 4);

    // reset mid-ACCUM aborts the conversion
    base = done_cnt;
    @(negedge clk);
    begin_f_b       = 1'b1;
    input_fibonacci = 32'hFFFF_FFFF;
    @(negedge clk);
    begin_f_b = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort done", convert_done, 0);
    chk("abort out", fibonacci_binary_out, 0);
    chk("abort ovf", overflow, 0);
    chk("abort nc", non_canonical, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort count", done_cnt - base, 0);

    conv("post", 32'h000000A4, 50, 0, 0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fibonacci_binary.md
Name: fibonacci_binary

Overview:
- Inverse of the binary-to-Fibonacci converter: decodes a Zeckendorf (Fibonacci-coded) word back to plain binary.
- Sequential: one code bit per clock, with the Fibonacci weight generated iteratively in-block and accumulated into a sum.
- Sits on the de-obfuscation path after the Fibonacci-domain stages. Uses the same begin/convert_done handshake as the encoder.

Parameters:
- FIB_W, 32, width of the Fibonacci-coded input word.
- BIN_W, 16, width of the binary output.
- ACC_W, 24, internal accumulator/weight width. Must hold the weight sum of an all-ones FIB_W word: 24 for FIB_W=32.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-low: sampled only on rising clk; rst=0 at an edge resets all state.
- begin_f_b  input  1  start request; sampled in IDLE only.
- input_fibonacci  input  FIB_W  Fibonacci-coded word; captured on the accepted begin cycle.
- convert_done  output  1  one-cycle pulse; result valid.
- fibonacci_binary_out  output  BIN_W  decoded value; held until the next convert_done.
- overflow  output  1  decoded sum exceeded 2^BIN_W-1; valid with convert_done, held.
- non_canonical  output  1  input had two adjacent 1 bits (not Zeckendorf); valid with convert_done, held.

Behaviour:
- Weight rule: bit i has weight F(i+2), with F(1)=F(2)=1. So bit0=1, bit1=2, bit2=3, bit3=5, bit4=8, and so on.
- Reset (rst=0 at an edge): state=IDLE; all outputs 0; shift register, accumulator, weights and index all 0.
- States are IDLE, ACCUM and DONE.
- IDLE:
  - If begin_f_b=1, capture input_fibonacci into the shift register.
  - Set acc=0, wa=1 (F2), wb=2 (F3), prev_bit=0, idx=0, err=0.
  - Go to ACCUM. Otherwise stay in IDLE.
- ACCUM, one cycle per bit:
  - If sr[0]=1, acc += wa.
  - If sr[0]=1 and prev_bit=1, set err=1.
  - Then: prev_bit<=sr[0]; sr<=sr>>1; wa<=wb; wb<=wa+wb; idx++.
  - Leave for DONE when the shifted sr is zero or idx==FIB_W-1. Take the exit in the same cycle as the final bit's accumulate.
- DONE:
  - convert_done=1 for exactly this cycle.
  - fibonacci_binary_out = (acc > 2^BIN_W-1) ? all-ones (saturate) : acc[BIN_W-1:0].
  - overflow = (acc > 2^BIN_W-1); non_canonical = err.
  - Next state is IDLE unconditionally.
- Latency:
  - begin accepted at edge T.
  - ACCUM occupies k = max(1, msb_index+1) cycles.
  - convert_done is high in cycle T+k+1.
  - An input of 0 therefore gives convert_done 2 cycles after begin.
- begin_f_b in ACCUM or DONE is ignored; no queueing. A begin in the DONE cycle is also ignored, because IDLE samples it one cycle later.
- begin_f_b held high continuously causes back-to-back conversions, one every k+2 cycles.
- input_fibonacci changes after capture have no effect.
- Reset mid-conversion: the next edge with rst=0 aborts to IDLE with outputs cleared; no convert_done is produced.
- Arithmetic:
  - All weight and accumulate arithmetic is unsigned, ACC_W wide.
  - wb may wrap past the last used weight; that value is never consumed.
- Outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package fib_pkg holds:
  - state enum (IDLE/ACCUM/DONE, 2-bit);
  - constants FIB_W_DEF=32, BIN_W_DEF=16, ACC_W_DEF=24;
  - a function giving F(n) for bench reference values.
- No sub-module: the iterative (wa, wb) pair replaces a separate Fibonacci calculator. The block is a single module.

Test Plan:
- Zero input: rst low 2 cycles, then begin with input 0 → convert_done 2 cycles later; out=0, overflow=0, non_canonical=0.
- Canonical decode: input 32'h000000A4 (bits 2, 5, 7 = 3+13+34) → out=50, convert_done at T+9, flags 0. Also input 32'h5 → out=4.
- Non-canonical: input 32'h3 → out=3, non_canonical=1. Next conversion with 32'h1 → out=1, non_canonical cleared to 0.
- Overflow boundary:
  - bit22 alone (F24=46368) → out=46368, overflow=0.
  - bit23 alone (F25=75025) → out=16'hFFFF, overflow=1.
  - all-ones 32-bit input → 16'hFFFF, overflow=1, non_canonical=1, convert_done at T+33.
- Handshake and reset:
  - begin pulses during ACCUM are ignored: exactly one convert_done per accepted start.
  - rst=0 asserted mid-ACCUM → no convert_done; outputs read 0 the following cycle.
  - A fresh begin after reset decodes correctly.
